// File: rtl/window_stream_gen.sv
// window_stream_gen: turns a raster pixel stream into one WIN x WIN
// neighbourhood per accepted pixel, once WIN-1 full lines and WIN-1 columns
// of the current line are available.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; m_valid never depends on m_ready, and m_window/m_col/m_row are
// held unchanged while m_valid && !m_ready.
module window_stream_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int WIN    = 6,
    localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         s_pixel,
    input  logic                      s_valid,
    input  logic                      s_sof,
    output logic                      s_ready,
    output logic [WIN*WIN*DATA_W-1:0] m_window,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [XW-1:0]             m_col,
    output logic [YW-1:0]             m_row,
    output logic                      frame_done,
    output logic [31:0]               window_count,
    output logic                      dbg_state
);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [XW-1:0] X_LAST      = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_FIRST_WIN = XW'(WIN - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_FIRST_WIN = YW'(WIN - 1);
    localparam logic [YW-1:0] Y_FILL_LAST = YW'(WIN - 2);

    state_t                    state_q;
    logic [XW-1:0]             x_q;
    logic [YW-1:0]             y_q;
    logic [DATA_W-1:0]         lb_q  [WIN-1][IMG_W];
    logic [DATA_W-1:0]         win_q [WIN][WIN];
    logic [DATA_W-1:0]         win_d [WIN][WIN];
    logic [DATA_W-1:0]         col_d [WIN];
    logic [WIN*WIN*DATA_W-1:0] win_flat_d;
    logic [WIN*WIN*DATA_W-1:0] m_window_q;
    logic                      m_valid_q;
    logic [XW-1:0]             m_col_q;
    logic [YW-1:0]             m_row_q;
    logic                      frame_done_q;
    logic [31:0]               window_count_q;

    logic                      s_ready_w;
    logic                      accept;
    logic                      emit;
    logic                      line_end;
    logic                      frame_end;
    logic [XW-1:0]             cur_x;
    logic [YW-1:0]             cur_y;
    state_t                    cur_state;

    // Accept decision and the effective position of this pixel; an accepted
    // start-of-frame pixel is treated as (0,0) and forces the fill phase.
    always_comb begin
        s_ready_w = !(m_valid_q && !m_ready);
        accept    = s_valid && s_ready_w;
        cur_x     = s_sof ? '0 : x_q;
        cur_y     = s_sof ? '0 : y_q;
        cur_state = s_sof ? FILL : state_q;
        line_end  = (cur_x == X_LAST);
        frame_end = line_end && (cur_y == Y_LAST);
        emit      = accept && (cur_state == RUN) && (cur_x >= X_FIRST_WIN);
    end

    // Next window: shift columns left, new column = line buffers (oldest
    // first) read at this x, with the incoming pixel at the bottom.
    always_comb begin
        for (int r = 0; r < WIN - 1; r++) begin
            col_d[r] = lb_q[r][cur_x];
        end
        col_d[WIN-1] = s_pixel;
        win_flat_d   = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][WIN-1] = col_d[r];
            for (int c = 0; c < WIN; c++) begin
                win_flat_d[(r*WIN+c)*DATA_W +: DATA_W] = win_d[r][c];
            end
        end
    end

    // Line buffers: at column x every line ages by one and the newest takes
    // the incoming pixel; the read above sees the values before this write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < WIN - 1; r++) begin
                for (int i = 0; i < IMG_W; i++) begin
                    lb_q[r][i] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < WIN - 2; r++) begin
                lb_q[r][cur_x] <= lb_q[r+1][cur_x];
            end
            lb_q[WIN-2][cur_x] <= s_pixel;
        end
    end

    // Column-shift register holding the neighbourhood around the last pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            win_q <= win_d;
        end
    end

    // Position counters, FILL/RUN state and the registered output stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= FILL;
            x_q            <= '0;
            y_q            <= '0;
            m_valid_q      <= 1'b0;
            m_window_q     <= '0;
            m_col_q        <= '0;
            m_row_q        <= '0;
            frame_done_q   <= 1'b0;
            window_count_q <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (m_valid_q && m_ready) begin
                window_count_q <= window_count_q + 32'd1;
            end
            if (emit) begin
                m_valid_q  <= 1'b1;
                m_window_q <= win_flat_d;
                m_col_q    <= cur_x - X_FIRST_WIN;
                m_row_q    <= cur_y - Y_FIRST_WIN;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
            if (accept) begin
                frame_done_q <= frame_end;
                if (frame_end) begin
                    x_q     <= '0;
                    y_q     <= '0;
                    state_q <= FILL;
                end else if (line_end) begin
                    x_q     <= '0;
                    y_q     <= cur_y + 1'b1;
                    state_q <= (cur_y == Y_FILL_LAST) ? RUN : cur_state;
                end else begin
                    x_q     <= cur_x + 1'b1;
                    y_q     <= cur_y;
                    state_q <= cur_state;
                end
            end
        end
    end

    assign s_ready      = s_ready_w;
    assign m_window     = m_window_q;
    assign m_valid      = m_valid_q;
    assign m_col        = m_col_q;
    assign m_row        = m_row_q;
    assign frame_done   = frame_done_q;
    assign window_count = window_count_q;
    assign dbg_state    = (state_q == RUN);

endmodule

// File: tb/tb_window_stream_gen.sv
// Bench for window_stream_gen on an 8x6 image with a 3x3 window: directed
// frames from the test plan plus randomized frames, all windows checked
// against an image-array reference model through an expected queue.
module tb_window_stream_gen;

    localparam int DW    = 8;
    localparam int IW    = 8;
    localparam int IH    = 6;
    localparam int WN    = 3;
    localparam int XW    = 3;
    localparam int YW    = 3;
    localparam int WBITS = WN * WN * DW;
    localparam int O_COL = WBITS;
    localparam int O_ROW = WBITS + XW;
    localparam int O_LST = WBITS + XW + YW;
    localparam int EXP_W = WBITS + XW + YW + 1;

    logic             clk;
    logic             reset;
    logic [DW-1:0]    s_pixel;
    logic             s_valid;
    logic             s_sof;
    logic             s_ready;
    logic [WBITS-1:0] m_window;
    logic             m_valid;
    logic             m_ready;
    logic [XW-1:0]    m_col;
    logic [YW-1:0]    m_row;
    logic             frame_done;
    logic [31:0]      window_count;
    logic             dbg_state;

    window_stream_gen #(
        .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .WIN(WN)
    ) dut (
        .clk(clk), .reset(reset),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
        .m_window(m_window), .m_valid(m_valid), .m_ready(m_ready),
        .m_col(m_col), .m_row(m_row), .frame_done(frame_done),
        .window_count(window_count), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got running, expected finished)");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [DW-1:0]    img [IH][IW];
    int               mx = 0, my = 0;
    int               n_push = 0, n_last = 0, fd_cnt = 0, acc_cnt = 0;
    bit               first_seen = 0;
    int               first_acc = 0;
    logic [WBITS-1:0] first_win;
    logic [XW-1:0]    first_col;
    logic [YW-1:0]    first_row;
    bit               sof_watch = 0;
    int               sof_acc = 0;
    bit               prev_stall = 0;
    logic [WBITS-1:0] prev_win;
    logic [XW-1:0]    prev_col;
    logic [YW-1:0]    prev_row;
    logic [EXP_W-1:0] e_item;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] elem(input logic [WBITS-1:0] w, input int r, input int c);
        return w[(r*WN+c)*DW +: DW];
    endfunction

    // Reference model: store each accepted pixel at its raster position in a
    // frame image; any position with WN-1 rows and columns before it yields
    // the window cut directly from the image.
    task automatic model_accept(input logic [DW-1:0] pix, input logic sof);
        logic [EXP_W-1:0] e;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        img[my][mx] = pix;
        if (mx >= WN - 1 && my >= WN - 1) begin
            e = '0;
            for (int r = 0; r < WN; r++) begin
                for (int c = 0; c < WN; c++) begin
                    e[(r*WN+c)*DW +: DW] = img[my-WN+1+r][mx-WN+1+c];
                end
            end
            e[O_COL +: XW] = XW'(mx - (WN - 1));
            e[O_ROW +: YW] = YW'(my - (WN - 1));
            e[O_LST]       = (mx == IW - 1) && (my == IH - 1);
            exp_q.push_back(e);
            n_push++;
            if (e[O_LST]) n_last++;
        end
        if (mx == IW - 1) begin
            mx = 0;
            my = (my == IH - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        mx = 0; my = 0;
        n_push = 0; n_last = 0; fd_cnt = 0; acc_cnt = 0;
        first_seen = 0; sof_watch = 0; sof_acc = 0; prev_stall = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 0;
        end else begin
            check_eq("s_ready_rule", s_ready, !(m_valid && !m_ready));
            if (prev_stall) begin
                check_eq("stall_valid", m_valid, 1'b1);
                check_eq("stall_window", m_window, prev_win);
                check_eq("stall_col", m_col, prev_col);
                check_eq("stall_row", m_row, prev_row);
            end
            if (frame_done) begin
                fd_cnt++;
                check_eq("fd_valid", m_valid, 1'b1);
                check_eq("fd_col", m_col, IW - WN);
                check_eq("fd_row", m_row, IH - WN);
            end
            if (!first_seen && m_valid) begin
                first_seen = 1;
                first_acc  = acc_cnt;
                first_win  = m_window;
                first_col  = m_col;
                first_row  = m_row;
            end
            if (sof_watch && m_valid) begin
                check_eq("sof_gap", sof_acc, (WN - 1) * IW + WN - 1);
                check_eq("sof_col", m_col, 0);
                check_eq("sof_row", m_row, 0);
                sof_watch = 0;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_window", m_valid, 1'b0);
                end else begin
                    e_item = exp_q.pop_front();
                    check_eq("window", m_window, e_item[WBITS-1:0]);
                    check_eq("col", m_col, e_item[O_COL +: XW]);
                    check_eq("row", m_row, e_item[O_ROW +: YW]);
                end
            end
            if (s_valid && s_ready) begin
                acc_cnt++;
                if (sof_watch) sof_acc++;
                model_accept(s_pixel, s_sof);
                if (s_sof) begin
                    sof_watch = 1;
                    sof_acc   = 0;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_win   = m_window;
            prev_col   = m_col;
            prev_row   = m_row;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_pixel(input logic [DW-1:0] pix, input logic sof, input bit rnd);
        int  n;
        bit  got;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                m_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b1;
        s_pixel = pix;
        s_sof   = sof;
        n = 0;
        forever begin
            m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            got = s_ready;
            @(posedge clk); #1;
            if (got) break;
            n++;
            if (n > 200) begin
                check_eq("accept_wait", got, 1'b1);
                break;
            end
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_s_ready"}, s_ready, 1'b1);
        check_eq({tag, "_m_valid"}, m_valid, 1'b0);
        check_eq({tag, "_m_window"}, m_window, 0);
        check_eq({tag, "_m_col"}, m_col, 0);
        check_eq({tag, "_m_row"}, m_row, 0);
        check_eq({tag, "_frame_done"}, frame_done, 1'b0);
        check_eq({tag, "_window_count"}, window_count, 0);
        check_eq({tag, "_state"}, dbg_state, 1'b0);
    endtask

    task automatic pulse_reset();
        reset   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        #1;
        check_reset_vals("midreset");
        model_clear();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic plain_frame_and_check(input string tag);
        for (int i = 0; i < IW * IH; i++) send_pixel(DW'(i), 1'b0, 1'b0);
        drain();
        check_eq({tag, "_first_acc"}, first_acc, 19);
        check_eq({tag, "_w00"}, elem(first_win, 0, 0), 0);
        check_eq({tag, "_w02"}, elem(first_win, 0, 2), 2);
        check_eq({tag, "_w20"}, elem(first_win, 2, 0), 16);
        check_eq({tag, "_w22"}, elem(first_win, 2, 2), 18);
        check_eq({tag, "_first_col"}, first_col, 0);
        check_eq({tag, "_first_row"}, first_row, 0);
        check_eq({tag, "_count"}, window_count, 24);
        check_eq({tag, "_fd_cnt"}, fd_cnt, 1);
        check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic totals_check(input string tag);
        check_eq({tag, "_count"}, window_count, n_push);
        check_eq({tag, "_fd_cnt"}, fd_cnt, n_last);
        check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_pixel = '0;
        m_ready = 1'b1;
        #2;
        check_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Frame A: pixel value = y*8+x, downstream always ready.
        plain_frame_and_check("frameA");

        // Frame B: backpressure for 5 cycles while the window of pixel 20 waits.
        for (int i = 0; i <= 20; i++) send_pixel(DW'(i), 1'b0, 1'b0);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_pixel = DW'(21);
        s_sof   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_s_ready", s_ready, 1'b0);
            check_eq("bp_m_valid", m_valid, 1'b1);
            check_eq("bp_window", m_window, exp_q[0][WBITS-1:0]);
            check_eq("bp_col", m_col, exp_q[0][O_COL +: XW]);
            check_eq("bp_row", m_row, exp_q[0][O_ROW +: YW]);
        end
        @(posedge clk); #1;
        for (int i = 21; i < IW * IH; i++) send_pixel(DW'(i), 1'b0, 1'b0);
        drain();
        check_eq("frameB_count", window_count, 48);
        totals_check("frameB");

        // Frame C: start-of-frame on the 30th pixel, then a complete new frame.
        for (int i = 0; i < 29; i++) send_pixel(DW'(i), 1'b0, 1'b0);
        send_pixel(8'hA5, 1'b1, 1'b0);
        for (int i = 1; i < IW * IH; i++) send_pixel(DW'($urandom_range(0, 255)), 1'b0, 1'b0);
        drain();
        check_eq("frameC_count", window_count, 81);
        check_eq("frameC_sof_seen", sof_watch, 1'b0);
        totals_check("frameC");

        // Frames D: random pixels, random gaps and random downstream stalls,
        // with sof asserted on each frame's first pixel.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < IW * IH; i++)
                send_pixel(DW'($urandom_range(0, 255)), (i == 0), 1'b1);
        end
        drain();
        totals_check("frameD");

        // Reset pulse mid-RUN, then the first scenario must repeat exactly.
        for (int i = 0; i < 31; i++) send_pixel(DW'($urandom_range(0, 255)), 1'b0, 1'b1);
        pulse_reset();
        plain_frame_and_check("frameE");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
